// File: rtl/mac_result_requant.sv
// ============================================================================
// Module      : mac_result_requant
// Description : Delta / round / shift / saturate stage for MAC accumulator
//               results, followed by a small drop-on-full FIFO with valid/ready.
//               Optional ReLU clamp enabled by defining MAC_REQUANT_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_result_requant #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ACC_W-1:0]           acc_in,
    input  logic                       acc_valid,
    input  logic [4:0]                 cfg_shift,
    input  logic                       cfg_delta,
    input  logic                       cfg_relu,
    input  logic                       clr_flags,
    output logic [OUT_W-1:0]           m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       sat_flag,
    output logic                       ovf_flag
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);
    localparam logic signed [ACC_W:0] c_max = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] c_min = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [ACC_W-1:0]   prev_acc_q, prev_acc_d;
    logic               s1_valid_q, s1_valid_d;
    logic [ACC_W-1:0]   s1_d_q, s1_d_d;
    logic [4:0]         s1_shift_q, s1_shift_d;
`ifdef MAC_REQUANT_RELU_EN
    logic               s1_relu_q, s1_relu_d;
`else
    logic               w_unused_relu;
    assign w_unused_relu = cfg_relu;
`endif

    logic [OUT_W-1:0]   mem_q [DEPTH];
    logic [OUT_W-1:0]   mem_d [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               sat_q, sat_d, ovf_q, ovf_d;

    logic signed [ACC_W:0] w_ext, w_rnd, w_sum, w_shr;
    logic [OUT_W-1:0]      w_res;
    logic                  w_clip, w_pop, w_push_ok;

    // S1: delta and configuration capture; prev_acc tracks every accepted value
    always_comb begin
        prev_acc_d = prev_acc_q;
        s1_d_d     = s1_d_q;
        s1_shift_d = s1_shift_q;
        s1_valid_d = acc_valid;
`ifdef MAC_REQUANT_RELU_EN
        s1_relu_d  = s1_relu_q;
`endif
        if (acc_valid) begin
            prev_acc_d = acc_in;
            s1_d_d     = cfg_delta ? (acc_in - prev_acc_q) : acc_in;
            s1_shift_d = cfg_shift;
`ifdef MAC_REQUANT_RELU_EN
            s1_relu_d  = cfg_relu;
`endif
        end
    end

    // S2: one extra bit of headroom keeps the rounding add from overflowing
    always_comb begin
        w_ext = {s1_d_q[ACC_W-1], s1_d_q};
`ifdef MAC_REQUANT_RELU_EN
        if (s1_relu_q && w_ext[ACC_W]) begin
            w_ext = '0;
        end
`endif
        w_rnd = '0;
        if (s1_shift_q != 5'd0) begin
            w_rnd = (ACC_W+1)'(1) << (s1_shift_q - 5'd1);
        end
        w_sum  = w_ext + w_rnd;
        w_shr  = w_sum >>> s1_shift_q;
        w_clip = 1'b0;
        w_res  = w_shr[OUT_W-1:0];
        if (w_shr > c_max) begin
            w_res  = c_max[OUT_W-1:0];
            w_clip = 1'b1;
        end else if (w_shr < c_min) begin
            w_res  = c_min[OUT_W-1:0];
            w_clip = 1'b1;
        end
    end

    // FIFO: a full FIFO still accepts a push when the head pops on the same edge
    always_comb begin
        w_pop     = (count_q != '0) && m_ready;
        w_push_ok = s1_valid_q && ((count_q != c_full) || w_pop);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (w_push_ok) begin
            mem_d[wr_ptr_q] = w_res;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        sat_d = (sat_q && !clr_flags) || (s1_valid_q && w_clip);
        ovf_d = (ovf_q && !clr_flags) || (s1_valid_q && !w_push_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_acc_q <= '0;
            s1_valid_q <= 1'b0;
            s1_d_q     <= '0;
            s1_shift_q <= '0;
`ifdef MAC_REQUANT_RELU_EN
            s1_relu_q  <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            prev_acc_q <= prev_acc_d;
            s1_valid_q <= s1_valid_d;
            s1_d_q     <= s1_d_d;
            s1_shift_q <= s1_shift_d;
`ifdef MAC_REQUANT_RELU_EN
            s1_relu_q  <= s1_relu_d;
`endif
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
        end
    end

    assign m_data     = mem_q[rd_ptr_q];
    assign m_valid    = (count_q != '0);
    assign fifo_count = count_q;
    assign sat_flag   = sat_q;
    assign ovf_flag   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_result_requant.sv
// ============================================================================
// Module      : tb_mac_result_requant
// Description : Directed self-checking bench for mac_result_requant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_result_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] acc_in;
    logic        acc_valid;
    logic [4:0]  cfg_shift;
    logic        cfg_delta;
    logic        cfg_relu;
    logic        clr_flags;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  fifo_count;
    logic        sat_flag;
    logic        ovf_flag;

    int checks = 0;
    int errors = 0;

    mac_result_requant #(.ACC_W(32), .OUT_W(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .acc_in(acc_in), .acc_valid(acc_valid),
        .cfg_shift(cfg_shift), .cfg_delta(cfg_delta), .cfg_relu(cfg_relu),
        .clr_flags(clr_flags), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .fifo_count(fifo_count), .sat_flag(sat_flag),
        .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;

    // One-cycle acc_valid pulse; returns on the negedge after the capture edge
    task automatic pulse(input logic [31:0] a, input logic [4:0] sh, input logic dl, input logic rl);
        @(negedge clk);
        acc_in = a; cfg_shift = sh; cfg_delta = dl; cfg_relu = rl; acc_valid = 1'b1;
        @(negedge clk);
        acc_valid = 1'b0;
    endtask

    // Samples the head at the current negedge, then pops it
    task automatic pop_head(output logic v, output logic [15:0] d);
        v = m_valid; d = m_data;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic clear_flags();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; acc_in = '0; acc_valid = 1'b0; cfg_shift = '0; cfg_delta = 1'b0;
        cfg_relu = 1'b0; clr_flags = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_valid, m_data, fifo_count, sat_flag, ovf_flag} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h c=%0d s=%b o=%b, want all 0",
                     m_valid, m_data, fifo_count, sat_flag, ovf_flag);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic v; logic [15:0] d;
        pulse(32'd1234, 5'd0, 1'b0, 1'b0);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL basic_latency_early: m_valid=%b want 0", m_valid);
        end
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd1) begin
            errors++; $display("FAIL basic_count1: got %0d want 1", fifo_count);
        end
        pop_head(v, d);
        checks++;
        if (v !== 1'b1 || d !== 16'd1234) begin
            errors++; $display("FAIL basic_data: got v=%b d=%0d want v=1 d=1234", v, d);
        end
        checks++;
        if (fifo_count !== 3'd0 || m_valid !== 1'b0 || sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_pop: got c=%0d v=%b s=%b want 0 0 0", fifo_count, m_valid, sat_flag);
        end
    endtask

    task automatic test_round_back_to_back();
        logic [31:0] ins [3] = '{32'd24, 32'hFFFF_FFE8, 32'd7};
        logic [15:0] exp [3] = '{16'd2, 16'hFFFF, 16'd0};
        logic v; logic [15:0] d;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            acc_in = ins[i]; cfg_shift = 5'd4; cfg_delta = 1'b0; acc_valid = 1'b1;
        end
        @(negedge clk);
        acc_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd3) begin
            errors++; $display("FAIL round_count: got %0d want 3", fifo_count);
        end
        for (int i = 0; i < 3; i++) begin
            pop_head(v, d);
            checks++;
            if (v !== 1'b1 || d !== exp[i]) begin
                errors++; $display("FAIL round_data%0d: got v=%b d=%h want v=1 d=%h", i, v, d, exp[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic v; logic [15:0] d;
        pulse(32'd100000, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        pop_head(v, d);
        checks++;
        if (v !== 1'b1 || d !== 16'h7FFF || sat_flag !== 1'b1) begin
            errors++; $display("FAIL sat_pos: got v=%b d=%h s=%b want 1 7fff 1", v, d, sat_flag);
        end
        pulse(32'hFFFE_7960, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        pop_head(v, d);
        checks++;
        if (v !== 1'b1 || d !== 16'h8000) begin
            errors++; $display("FAIL sat_neg: got v=%b d=%h want 1 8000", v, d);
        end
        clear_flags();
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++; $display("FAIL sat_clear: got %b want 0", sat_flag);
        end
    endtask

    task automatic test_delta();
        logic [31:0] ins [5] = '{32'd0, 32'd100, 32'd250, 32'h7FFF_FFF0, 32'h8000_0010};
        logic        dl  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [15:0] exp [5] = '{16'd0, 16'd100, 16'd150, 16'h7FFF, 16'd32};
        logic v; logic [15:0] d;
        for (int i = 0; i < 5; i++) begin
            pulse(ins[i], 5'd0, dl[i], 1'b0);
            @(negedge clk);
            pop_head(v, d);
            checks++;
            if (v !== 1'b1 || d !== exp[i]) begin
                errors++; $display("FAIL delta%0d: got v=%b d=%h want v=1 d=%h", i, v, d, exp[i]);
            end
        end
        clear_flags();
    endtask

    task automatic test_overflow();
        logic v; logic [15:0] d;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            acc_in = 32'(i); cfg_shift = 5'd0; cfg_delta = 1'b0; acc_valid = 1'b1;
        end
        @(negedge clk);
        acc_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd4 || ovf_flag !== 1'b1) begin
            errors++; $display("FAIL ovf_full: got c=%0d o=%b want 4 1", fifo_count, ovf_flag);
        end
        for (int i = 1; i <= 4; i++) begin
            pop_head(v, d);
            checks++;
            if (v !== 1'b1 || d !== 16'(i)) begin
                errors++; $display("FAIL ovf_drain%0d: got v=%b d=%0d want v=1 d=%0d", i, v, d, i);
            end
        end
        clear_flags();
        for (int i = 10; i <= 13; i++) begin
            pulse(32'(i), 5'd0, 1'b0, 1'b0);
        end
        repeat (2) @(negedge clk);
        // Push of 14 lands on the same edge as a pop of the full FIFO
        @(negedge clk);
        acc_in = 32'd14; acc_valid = 1'b1;
        @(negedge clk);
        acc_valid = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        checks++;
        if (fifo_count !== 3'd4 || ovf_flag !== 1'b0) begin
            errors++; $display("FAIL full_pop_push: got c=%0d o=%b want 4 0", fifo_count, ovf_flag);
        end
        for (int i = 11; i <= 14; i++) begin
            pop_head(v, d);
            checks++;
            if (v !== 1'b1 || d !== 16'(i)) begin
                errors++; $display("FAIL full_drain%0d: got v=%b d=%0d want v=1 d=%0d", i, v, d, i);
            end
        end
    endtask

    task automatic test_relu_and_async_reset();
        logic v; logic [15:0] d; logic [15:0] exp;
`ifdef MAC_REQUANT_RELU_EN
        exp = 16'd0;
`else
        exp = 16'hFFCE;
`endif
        pulse(32'hFFFF_FFCE, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        pop_head(v, d);
        checks++;
        if (v !== 1'b1 || d !== exp || sat_flag !== 1'b0) begin
            errors++; $display("FAIL relu: got v=%b d=%h s=%b want 1 %h 0", v, d, sat_flag, exp);
        end
        pulse(32'd7, 5'd0, 1'b0, 1'b0);
        pulse(32'd8, 5'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd2) begin
            errors++; $display("FAIL prereset_count: got %0d want 2", fifo_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL async_reset: got v=%b c=%0d want 0 0", m_valid, fifo_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_back_to_back();
        test_saturation();
        test_delta();
        test_overflow();
        test_relu_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
